// File: rtl/xnorpop_pkg.sv
// Shared definitions for the XNOR-popcount stream controller and datapath:
// sequencer state encoding and result-width derivation.
package xnorpop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EVAL = 2'd2
  } state_t;

  // Width of the popcount result; majority mode counts pop_size/3 groups.
  function automatic int unsigned result_size_f(input int unsigned pop_size, input bit majority);
    int unsigned n;
    n = majority ? (pop_size / 3) : pop_size;
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/XNORPop.sv
// Combinational XNOR popcount; in majority mode each consecutive bit triple
// contributes one count when at least two of its bits match.
module XNORPop
  import xnorpop_pkg::*;
#(
  parameter bit          Majority_enable = 1'b0,
  parameter int unsigned pop_size        = 576,
  localparam int unsigned result_size    = result_size_f(pop_size, Majority_enable)
) (
  input  logic [pop_size-1:0]    a,
  input  logic [pop_size-1:0]    w,
  output logic [result_size-1:0] pop
);

  logic [pop_size-1:0] xn;

  assign xn = ~(a ^ w);

  always_comb begin
    int unsigned acc;
    int unsigned grp;
    acc = 0;
    grp = 0;
    if (Majority_enable) begin
      for (int g = 0; g < int'(pop_size / 3); g++) begin
        grp = 32'(xn[3*g]) + 32'(xn[3*g+1]) + 32'(xn[3*g+2]);
        if (grp >= 2) acc = acc + 1;
      end
    end else begin
      for (int i = 0; i < int'(pop_size); i++) acc = acc + 32'(xn[i]);
    end
    pop = result_size'(acc);
  end

endmodule

// File: rtl/xnorpop_stream_ctrl.sv
// Bit-serial front end for XNORPop: assembles frames from a valid/ready bit
// stream, evaluates once per frame and hands the result downstream.
module xnorpop_stream_ctrl
  import xnorpop_pkg::*;
#(
  parameter bit          Majority_enable = 1'b0,
  parameter int unsigned pop_size        = 576,
  localparam int unsigned result_size    = result_size_f(pop_size, Majority_enable),
  localparam int unsigned cnt_w          = (pop_size > 1) ? $clog2(pop_size) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   a,
  input  logic                   w,
  input  logic                   flush,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [result_size-1:0] pop,
  output logic [15:0]            frame_cnt,
  output logic                   busy
);

  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(pop_size - 1);

  state_t                 state;
  logic [cnt_w-1:0]       cnt;
  logic [pop_size-1:0]    a_reg;
  logic [pop_size-1:0]    w_reg;
  logic [result_size-1:0] pop_c;
  logic                   accept;

  // Only the frame-completing bit waits on a pending result, so EVAL never
  // overwrites an undelivered pop.
  assign in_ready = (state != EVAL) && !((cnt == cnt_last) && pop_valid) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE) || pop_valid;

  XNORPop #(
    .Majority_enable(Majority_enable),
    .pop_size       (pop_size)
  ) u_xnorpop (
    .a  (a_reg),
    .w  (w_reg),
    .pop(pop_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      w_reg     <= '0;
      pop       <= '0;
      pop_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (pop_valid && pop_ready) begin
        pop_valid <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state)
        IDLE, FILL: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (accept) begin
            a_reg <= pop_size'({a_reg, a});
            w_reg <= pop_size'({w_reg, w});
            if (cnt == cnt_last) begin
              cnt   <= '0;
              state <= EVAL;
            end else begin
              cnt   <= cnt + cnt_w'(1);
              state <= FILL;
            end
          end
        end
        EVAL: begin
          pop       <= pop_c;
          pop_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnorpop_stream_ctrl.sv
// Randomised and directed bench for xnorpop_stream_ctrl (normal and majority
// instances driven in lockstep) against a frame-level reference model.
module tb_xnorpop_stream_ctrl;

  localparam int unsigned PS = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, a, w, flush, pop_ready;
  logic       in_ready, pop_valid, busy;
  logic [3:0] pop;
  logic [15:0] frame_cnt;
  logic       in_ready_m, pop_valid_m, busy_m;
  logic [1:0] pop_m;
  logic [15:0] frame_cnt_m;

  int checks = 0;
  int errors = 0;

  // Reference model: current frame as arrival-ordered bit queues.
  bit fa[$];
  bit fw[$];
  bit m_eval;
  bit m_pv;
  int m_res_n, m_res_m;
  int m_pop_n, m_pop_m;
  int m_frames;

  always #5 clk = ~clk;

  xnorpop_stream_ctrl #(.Majority_enable(1'b0), .pop_size(PS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .w(w), .flush(flush), .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop(pop), .frame_cnt(frame_cnt), .busy(busy)
  );

  xnorpop_stream_ctrl #(.Majority_enable(1'b1), .pop_size(PS)) dut_maj (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
    .a(a), .w(w), .flush(flush), .pop_valid(pop_valid_m), .pop_ready(pop_ready),
    .pop(pop_m), .frame_cnt(frame_cnt_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fa.delete();
    fw.delete();
    m_eval   = 1'b0;
    m_pv     = 1'b0;
    m_pop_n  = 0;
    m_pop_m  = 0;
    m_frames = 0;
  endtask

  task automatic check_outputs(input bit exp_rdy);
    bit exp_busy;
    exp_busy = m_eval || (fa.size() > 0) || m_pv;
    check("in_ready", in_ready, exp_rdy);
    check("in_ready_maj", in_ready_m, exp_rdy);
    check("pop_valid", pop_valid, m_pv);
    check("pop_valid_maj", pop_valid_m, m_pv);
    check("pop", pop, m_pop_n);
    check("pop_maj", pop_m, m_pop_m);
    check("frame_cnt", frame_cnt, m_frames);
    check("frame_cnt_maj", frame_cnt_m, m_frames);
    check("busy", busy, exp_busy);
    check("busy_maj", busy_m, exp_busy);
  endtask

  // One clock cycle: drive, check, then advance the model across the edge.
  task automatic step(input bit iv, input bit av, input bit wv, input bit fl,
                      input bit pr, output bit acc);
    bit exp_rdy;
    int grp;
    @(negedge clk);
    in_valid = iv; a = av; w = wv; flush = fl; pop_ready = pr;
    #1;
    exp_rdy = !m_eval && !((fa.size() == PS - 1) && m_pv) && !fl;
    check_outputs(exp_rdy);
    acc = iv && exp_rdy;
    if (m_pv && pr) begin
      m_pv     = 1'b0;
      m_frames = (m_frames + 1) % 65536;
    end
    if (m_eval) begin
      m_eval  = 1'b0;
      m_pv    = 1'b1;
      m_pop_n = m_res_n;
      m_pop_m = m_res_m;
    end else if (fl) begin
      fa.delete();
      fw.delete();
    end else if (acc) begin
      fa.push_back(av);
      fw.push_back(wv);
      if (fa.size() == PS) begin
        m_res_n = 0;
        m_res_m = 0;
        for (int i = 0; i < int'(PS); i++) m_res_n += (fa[i] == fw[i]) ? 1 : 0;
        for (int g = 0; g < int'(PS / 3); g++) begin
          grp = 0;
          for (int k = 0; k < 3; k++) grp += (fa[3*g+k] == fw[3*g+k]) ? 1 : 0;
          if (grp >= 2) m_res_m++;
        end
        fa.delete();
        fw.delete();
        m_eval = 1'b1;
      end
    end
  endtask

  // Offer one pair until the model says it is taken; bounded wait.
  task automatic send_bit(input bit av, input bit wv, input bit pr);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(1'b1, av, wv, 1'b0, pr, acc);
      n++;
    end
    check("send_accept", acc, 1);
  endtask

  // kind: 0 all equal, 1 first five equal, 2 all unequal
  task automatic send_frame(input int kind, input bit pr);
    bit av;
    bit eq;
    for (int i = 0; i < int'(PS); i++) begin
      av = 1'($urandom);
      case (kind)
        0:       eq = 1'b1;
        1:       eq = (i < 5);
        default: eq = 1'b0;
      endcase
      send_bit(av, eq ? av : ~av, pr);
    end
  endtask

  task automatic idle(input int n, input bit pr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, pr, acc);
  endtask

  initial begin
    bit acc;
    reset = 1'b1;
    in_valid = 1'b0; a = 1'b0; w = 1'b0; flush = 1'b0; pop_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs(1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Basic frames with delivery enabled.
    send_frame(0, 1'b1);
    idle(3, 1'b1);
    send_frame(1, 1'b1);
    idle(3, 1'b1);
    send_frame(2, 1'b1);
    idle(3, 1'b1);

    // Back-to-back frames with downstream stalled, then one-cycle release.
    send_frame(0, 1'b0);
    for (int i = 0; i < int'(PS) - 1; i++) send_bit(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // Flush after four accepts, then a full frame; flush during EVAL.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    send_frame(0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Async reset mid-frame with a pending result.
    send_frame(1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b1);
    @(negedge clk);
    reset = 1'b0;
    send_frame(0, 1'b1);
    idle(3, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, acc);
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
